// File: rtl/bool_lut_eval_if.sv
// Bundle of the evaluator's data, table-load and edge-counter signals.
// Ports: in/load_start/load_valid/load_bit/cnt_clr driven by the master;
//        out/busy/load_done/rise_cnt driven by the slave (the evaluator).
interface bool_lut_eval_if #(
    parameter int N_IN  = 5,
    parameter int CNT_W = 8
);
    logic [N_IN-1:0]  in;
    logic             out;
    logic             load_start;
    logic             load_valid;
    logic             load_bit;
    logic             busy;
    logic             load_done;
    logic             cnt_clr;
    logic [CNT_W-1:0] rise_cnt;

    modport master (
        output in, load_start, load_valid, load_bit, cnt_clr,
        input  out, busy, load_done, rise_cnt
    );

    modport slave (
        input  in, load_start, load_valid, load_bit, cnt_clr,
        output out, busy, load_done, rise_cnt
    );
endinterface

// File: rtl/bool_lut_eval.sv
// Registered N-input Boolean function evaluator driven by a 2^N_IN-bit truth table.
// Latency: in -> out is 2 cycles, 1 result per cycle; rise_cnt follows out by 1 cycle.
// Load: serial MSB-first into a shadow table, swapped atomically; load_valid gaps stall the load.
// Ports: clk, rst (sync, active-high), bus (slave side of bool_lut_eval_if).
module bool_lut_eval #(
    parameter int                     N_IN       = 5,
    parameter int                     CNT_W      = 8,
    parameter logic [(2**N_IN)-1:0]   TABLE_INIT = 32'hB0B0B000
) (
    input  logic              clk,
    input  logic              rst,
    bool_lut_eval_if.slave    bus
);
    localparam int TW = 2**N_IN;
    localparam logic [N_IN:0]      LAST_BIT = (N_IN+1)'(TW - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [N_IN:0]     bit_cnt_q,  bit_cnt_d;
    logic [TW-1:0]     shadow_q,   shadow_d;
    logic [TW-1:0]     active_q,   active_d;
    logic              done_q,     done_d;
    logic [N_IN-1:0]   in_q,       in_d;
    logic              out_q,      out_d;
    logic              out_prev_q, out_prev_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    // Bits arrive MSB first, so bit k lands at TW-1-k, which for a
    // power-of-two table is simply the bitwise inverse of the count.
    logic [N_IN-1:0]   wr_idx;
    assign wr_idx = ~bit_cnt_q[N_IN-1:0];

    // Table-load FSM
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d   = LOAD;
                    bit_cnt_d = '0;
                end
            end
            LOAD: begin
                // A fresh load_start restarts the load and drops that cycle's bit.
                if (bus.load_start) begin
                    bit_cnt_d = '0;
                end else if (bus.load_valid) begin
                    shadow_d[wr_idx] = bus.load_bit;
                    bit_cnt_d        = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                active_d = shadow_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Evaluation path and edge counter
    always_comb begin
        in_d       = bus.in;
        out_d      = active_q[in_q];
        out_prev_d = out_q;
        cnt_d      = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (out_q && !out_prev_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shadow_q   <= TABLE_INIT;
            active_q   <= TABLE_INIT;
            done_q     <= 1'b0;
            in_q       <= '0;
            out_q      <= 1'b0;
            out_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            done_q     <= done_d;
            in_q       <= in_d;
            out_q      <= out_d;
            out_prev_q <= out_prev_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.load_done = done_q;
    assign bus.rise_cnt  = cnt_q;
endmodule
